periferico_rx_fifo: RTL and testbench

- Peripheral-side receive stage directly downstream of machineCPU's send/ack/dados link; a drop-in receiver alternative to periferico's single-register capture.
- Synchronises the CPU's asynchronous send strobe and completes a four-phase handshake (send↑ → ack↑ → send↓ → ack↓).
- Queues each received 4-bit word in a small FIFO read by local peripheral logic.
- Applies backpressure by withholding ack while the FIFO is full.

---
 rtl/periferico_pkg.sv | 17 +
 rtl/sincronizador.sv | 22 ++
 rtl/periferico_rx_fifo.sv | 104 ++++++++++
 tb/tb_periferico_rx_fifo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/periferico_pkg.sv
// Shared constants for the peripheral-side receive path: FSM state
// encodings and default datapath sizes.
package periferico_pkg;

  localparam int DEF_DATA_W      = 4;
  localparam int DEF_DEPTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;

  // Encoding is visible on estadoPeriferico, so values are fixed.
  typedef enum logic [1:0] {
    IDLE       = 2'b00,
    WAIT_SPACE = 2'b01,
    WRITE      = 2'b10,
    WAIT_LOW   = 2'b11
  } estado_t;

endpackage

// File: rtl/sincronizador.sv
// Multi-flop synchroniser for a single asynchronous level. The synchronous
// reset value is a parameter so a held-high strobe is not mistaken for a new edge.
module sincronizador #(
  parameter int       STAGES  = 2,
  parameter logic     RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) chain <= {STAGES{RST_VAL}};
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/periferico_rx_fifo.sv
// Receive stage for the CPU send/ack/dados link: four-phase handshake into a
// first-word-fall-through FIFO, withholding ack while the FIFO is full.
module periferico_rx_fifo
  import periferico_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     send,
  input  logic [DATA_W-1:0]        dados,
  output logic                     ack,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [1:0]               estadoPeriferico
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] ONE = CW'(1);

  logic              send_s;
  estado_t           state_q, state_d;
  logic              ack_d;
  logic              wr, rd;
  logic [PW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] mem [DEPTH];

  sincronizador #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_send (
    .clk (clk),
    .rst (rst),
    .d   (send),
    .q   (send_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= WAIT_LOW;
      ack     <= 1'b0;
    end else begin
      state_q <= state_d;
      ack     <= ack_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = 1'b0;
    wr      = 1'b0;
    case (state_q)
      IDLE: begin
        if (send_s) state_d = full ? WAIT_SPACE : WRITE;
      end
      WAIT_SPACE: begin
        if (!full) state_d = WRITE;
      end
      WRITE: begin
        wr      = 1'b1;
        ack_d   = 1'b1;
        state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        // Leaving reset lands here with ack=0, so holding ack keeps it low.
        if (!send_s) state_d = IDLE;
        else         ack_d   = ack;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rd = rd_en && !empty;

  // Storage is not reset; flushing is done by clearing pointers and count.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= dados;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  assign empty            = (count == '0);
  assign full             = (count == CW'(DEPTH));
  assign rd_data          = mem[rptr];
  assign estadoPeriferico = state_q;

endmodule

// File: tb/tb_periferico_rx_fifo.sv
// Directed bench for periferico_rx_fifo: handshake latency, backpressure,
// pointer wrap, simultaneous push/pop, empty reads and mid-handshake reset.
module tb_periferico_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       send;
  logic [3:0] dados;
  logic       ack;
  logic       rd_en;
  logic [3:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic [1:0] estadoPeriferico;

  int total = 0;
  int fails = 0;

  localparam logic [1:0] S_IDLE = 2'b00, S_WSPACE = 2'b01, S_WRITE = 2'b10, S_WLOW = 2'b11;

  periferico_rx_fifo #(.DATA_W(4), .DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .send             (send),
    .dados            (dados),
    .ack              (ack),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .empty            (empty),
    .full             (full),
    .count            (count),
    .estadoPeriferico (estadoPeriferico)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input logic v, input string tag);
    int n = 0;
    while (ack !== v && n < 100) begin step(); n++; end
    chk(tag, 32'(ack), 32'(v));
  endtask

  task automatic wait_state(input logic [1:0] s, input string tag);
    int n = 0;
    while (estadoPeriferico !== s && n < 100) begin step(); n++; end
    chk(tag, 32'(estadoPeriferico), 32'(s));
  endtask

  task automatic send_word(input logic [3:0] d);
    wait_state(S_IDLE, "xfer_idle");
    send  = 1'b1;
    dados = d;
    wait_ack(1'b1, "xfer_ack_hi");
    send  = 1'b0;
    dados = 4'h0;
    wait_ack(1'b0, "xfer_ack_lo");
  endtask

  task automatic pop(input logic [3:0] exp, input string tag);
    chk(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    int ack_seen;
    int maxcnt;
    rst = 1'b1; send = 1'b0; dados = 4'h0; rd_en = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_state", 32'(estadoPeriferico), 32'(S_WLOW));
    chk("rst_ack",   32'(ack),   0);
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full",  32'(full),  0);

    // Single transfer with exact latency
    wait_state(S_IDLE, "t1_idle");
    send = 1'b1; dados = 4'hA;
    step(); step(); step();
    chk("t1_ack_early", 32'(ack), 0);
    step();
    chk("t1_ack_n3", 32'(ack), 1);
    chk("t1_rd_data", 32'(rd_data), 32'hA);
    chk("t1_count", 32'(count), 1);
    send = 1'b0;
    step(); step();
    chk("t1_ack_hold", 32'(ack), 1);
    step();
    chk("t1_ack_fall", 32'(ack), 0);
    chk("t1_state_idle", 32'(estadoPeriferico), 32'(S_IDLE));
    pop(4'hA, "t1_pop");
    chk("t1_empty", 32'(empty), 1);

    // Fill and backpressure
    for (int i = 1; i <= 4; i++) send_word(4'(i));
    chk("t2_full", 32'(full), 1);
    chk("t2_count", 32'(count), 4);
    send = 1'b1; dados = 4'h5;
    step(); step(); step(); step();
    chk("t2_wait_space", 32'(estadoPeriferico), 32'(S_WSPACE));
    ack_seen = 0;
    for (int i = 0; i < 20; i++) begin step(); if (ack) ack_seen = 1; end
    chk("t2_ack_withheld", 32'(ack_seen), 0);
    chk("t2_still_wait", 32'(estadoPeriferico), 32'(S_WSPACE));
    pop(4'h1, "t2_pop1");
    wait_ack(1'b1, "t2_ack_after_pop");
    send = 1'b0;
    wait_ack(1'b0, "t2_ack_lo");
    chk("t2_count_refill", 32'(count), 4);
    for (int i = 2; i <= 5; i++) pop(4'(i), "t2_order");
    chk("t2_empty", 32'(empty), 1);

    // Pointer wrap with alternating write/read
    maxcnt = 0;
    for (int i = 0; i < 10; i++) begin
      send_word(4'(i));
      if (int'(count) > maxcnt) maxcnt = int'(count);
      pop(4'(i), "t3_value");
    end
    chk("t3_maxcount", 32'(maxcnt), 1);
    chk("t3_empty", 32'(empty), 1);

    // Pop on the same edge as a write
    send_word(4'h7);
    chk("t4_pre_count", 32'(count), 1);
    send = 1'b1; dados = 4'hC;
    wait_state(S_WRITE, "t4_in_write");
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t4_count", 32'(count), 1);
    chk("t4_rd_data", 32'(rd_data), 32'hC);
    chk("t4_not_empty", 32'(empty), 0);
    send = 1'b0;
    wait_ack(1'b0, "t4_ack_lo");
    pop(4'hC, "t4_pop");

    // Reads on an empty FIFO are ignored
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) step();
    rd_en = 1'b0;
    chk("t5_count", 32'(count), 0);
    chk("t5_empty", 32'(empty), 1);
    send_word(4'h3);
    chk("t5_count1", 32'(count), 1);
    pop(4'h3, "t5_readback");

    // Reset while waiting for send to drop
    send_word(4'h2);
    send = 1'b1; dados = 4'h9;
    wait_ack(1'b1, "t6_ack_hi");
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_ack", 32'(ack), 0);
    chk("t6_count", 32'(count), 0);
    chk("t6_empty", 32'(empty), 1);
    for (int i = 0; i < 10; i++) step();
    chk("t6_hold_state", 32'(estadoPeriferico), 32'(S_WLOW));
    chk("t6_no_capture", 32'(count), 0);
    chk("t6_ack_low", 32'(ack), 0);
    send = 1'b0;
    wait_state(S_IDLE, "t6_release");
    send_word(4'hF);
    chk("t6_count1", 32'(count), 1);
    pop(4'hF, "t6_readback");
    chk("t6_final_empty", 32'(empty), 1);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
